wb_writer: RTL and testbench

Write-side driver for the CPU register file. It accepts single-cycle writeback results from the main pipeline and out-of-band results from long-latency units (multiplier/divider, cache-miss loads). It arbitrates the two sources onto the register file's single write port (`L_S`, `Wt_addr`, `Wt_data`) and buffers long-latency results in a small FIFO. It also keeps a 32-bit scoreboard of destinations with outstanding long-latency writes, which the hazard unit reads to stall dependent instructions.

---
 rtl/wb_writer_if.sv | 27 ++
 rtl/wb_writer.sv | 116 +++++++++++
 tb/tb_wb_writer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_writer_if.sv
// Register-file writeback bus: pipeline and long-latency result inputs, issue/scoreboard
// signals, and the single registered write port.
interface wb_writer_if;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] busy;
  logic        L_S;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;

  modport master (
    output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data, iss_valid, iss_addr,
    input  lu_ready, busy, L_S, Wt_addr, Wt_data
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data, iss_valid, iss_addr,
    output lu_ready, busy, L_S, Wt_addr, Wt_data
  );
endinterface

// File: rtl/wb_writer.sv
// Register-file write arbiter: pipeline writeback has priority, long-latency results are
// buffered in a FIFO, and a busy scoreboard tracks pending long-latency destinations.
// Optional macro WB_WRITER_BYPASS_EN lets a result skip an empty FIFO when the slot is free.
module wb_writer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_writer_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [4:0]  addr_mem [FIFO_DEPTH];
  logic [31:0] data_mem [FIFO_DEPTH];

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic        l_s_q, l_s_d;
  logic        lu_src_q, lu_src_d;
  logic [4:0]  wt_addr_q, wt_addr_d;
  logic [31:0] wt_data_q, wt_data_d;
  logic [31:0] busy_q, busy_d;

  logic wb_own, full, empty, lu_fire, lu_keep, bypass, push, pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign wb_own  = bus.wb_valid && (bus.wb_addr != 5'd0);
  assign lu_fire = bus.lu_valid && !full;
  // Results to x0 are handshaken but never stored or written.
  assign lu_keep = lu_fire && (bus.lu_addr != 5'd0);

`ifdef WB_WRITER_BYPASS_EN
  assign bypass = lu_keep && empty && !wb_own;
`else
  assign bypass = 1'b0;
`endif

  assign push = lu_keep && !bypass;
  assign pop  = !wb_own && !empty;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    l_s_d     = 1'b0;
    lu_src_d  = 1'b0;
    wt_addr_d = wt_addr_q;
    wt_data_d = wt_data_q;
    busy_d    = busy_q;

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

    if (wb_own) begin
      l_s_d     = 1'b1;
      wt_addr_d = bus.wb_addr;
      wt_data_d = bus.wb_data;
    end else if (pop) begin
      l_s_d     = 1'b1;
      lu_src_d  = 1'b1;
      wt_addr_d = addr_mem[rd_ptr_q[AW-1:0]];
      wt_data_d = data_mem[rd_ptr_q[AW-1:0]];
    end else if (bypass) begin
      l_s_d     = 1'b1;
      lu_src_d  = 1'b1;
      wt_addr_d = bus.lu_addr;
      wt_data_d = bus.lu_data;
    end

    // Clear for the write currently on the port, then set, so a reissue wins.
    if (l_s_q && lu_src_q) busy_d[wt_addr_q] = 1'b0;
    if (bus.iss_valid)     busy_d[bus.iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      l_s_q     <= 1'b0;
      lu_src_q  <= 1'b0;
      wt_addr_q <= 5'd0;
      wt_data_q <= 32'd0;
      busy_q    <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      l_s_q     <= l_s_d;
      lu_src_q  <= lu_src_d;
      wt_addr_q <= wt_addr_d;
      wt_data_q <= wt_data_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: FIFO storage is not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[AW-1:0]] <= bus.lu_addr;
      data_mem[wr_ptr_q[AW-1:0]] <= bus.lu_data;
    end
  end

  assign bus.lu_ready = !full;
  assign bus.busy     = busy_q;
  assign bus.L_S      = l_s_q;
  assign bus.Wt_addr  = wt_addr_q;
  assign bus.Wt_data  = wt_data_q;

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: reset, pipeline priority, FIFO ordering/backpressure,
// scoreboard set/clear, long-latency latency with or without WB_WRITER_BYPASS_EN.
module tb_wb_writer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  wb_writer_if bus();

  wb_writer #(.FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs held during one cycle; returns 1 time unit into the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid  = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    bus.lu_valid  = 1'b0; bus.lu_addr = 5'd0; bus.lu_data = 32'd0;
    bus.iss_valid = 1'b0; bus.iss_addr = 5'd0;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".L_S"}, {31'd0, bus.L_S}, 32'd1);
    check({tag, ".addr"}, {27'd0, bus.Wt_addr}, {27'd0, a});
    check({tag, ".data"}, bus.Wt_data, d);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    // Reset with a long-latency result offered
    rst = 1'b1;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd3; bus.lu_data = 32'h3333_3333;
    tick();
    rst = 1'b0;
    idle_inputs();
    check("rst.L_S", {31'd0, bus.L_S}, 32'd0);
    check("rst.busy", bus.busy, 32'd0);
    check("rst.lu_ready", {31'd0, bus.lu_ready}, 32'd1);
    check("rst.addr", {27'd0, bus.Wt_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.no_write", {31'd0, bus.L_S}, 32'd0);
    end

    // Pipeline write, then x0 request drops the slot and outputs hold
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    tick();
    expect_write("pipe", 5'd5, 32'hDEAD_BEEF);
    bus.wb_addr = 5'd0; bus.wb_data = 32'h0BAD_0BAD;
    tick();
    check("x0.L_S", {31'd0, bus.L_S}, 32'd0);
    check("x0.hold_addr", {27'd0, bus.Wt_addr}, 32'd5);
    check("x0.hold_data", bus.Wt_data, 32'hDEAD_BEEF);
    bus.wb_valid = 1'b0;

    // Conflict: pipeline writes r1..r3 first, then the buffered r7 result
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    check("conf.busy_set", bus.busy, 32'h0000_0080);
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = 32'h0000_1234;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h11;
    check("conf.lu_ready", {31'd0, bus.lu_ready}, 32'd1);
    tick();
    bus.lu_valid = 1'b0;
    expect_write("conf.w1", 5'd1, 32'h11);
    bus.wb_addr = 5'd2; bus.wb_data = 32'h22;
    tick();
    expect_write("conf.w2", 5'd2, 32'h22);
    bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    tick();
    expect_write("conf.w3", 5'd3, 32'h33);
    check("conf.busy_held", bus.busy, 32'h0000_0080);
    bus.wb_valid = 1'b0;
    tick();
    expect_write("conf.r7", 5'd7, 32'h0000_1234);
    check("conf.busy_during", bus.busy, 32'h0000_0080);
    tick();
    check("conf.idle", {31'd0, bus.L_S}, 32'd0);
    check("conf.busy_clr", bus.busy, 32'd0);

    // FIFO full: pipeline holds the slot while three results are offered
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h44;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd10; bus.lu_data = 32'hAAAA_0010;
    check("full.rdy0", {31'd0, bus.lu_ready}, 32'd1);
    tick();
    bus.lu_addr = 5'd11; bus.lu_data = 32'hAAAA_0011;
    check("full.rdy1", {31'd0, bus.lu_ready}, 32'd1);
    tick();
    bus.lu_addr = 5'd12; bus.lu_data = 32'hAAAA_0012;
    check("full.rdy_low", {31'd0, bus.lu_ready}, 32'd0);
    tick();
    check("full.rdy_low2", {31'd0, bus.lu_ready}, 32'd0);
    expect_write("full.pipe", 5'd4, 32'h44);
    bus.wb_valid = 1'b0;
    tick();
    expect_write("full.d10", 5'd10, 32'hAAAA_0010);
    check("full.rdy_back", {31'd0, bus.lu_ready}, 32'd1);
    tick();
    bus.lu_valid = 1'b0;
    expect_write("full.d11", 5'd11, 32'hAAAA_0011);
    tick();
    expect_write("full.d12", 5'd12, 32'hAAAA_0012);
    check("full.rdy_end", {31'd0, bus.lu_ready}, 32'd1);
    tick();
    check("full.drained", {31'd0, bus.L_S}, 32'd0);

    // Long-latency result to x0: accepted, never written
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd0; bus.lu_data = 32'hFFFF_FFFF;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
    tick();
    idle_inputs();
    check("lux0.L_S1", {31'd0, bus.L_S}, 32'd0);
    check("lux0.busy", bus.busy, 32'd0);
    tick();
    check("lux0.L_S2", {31'd0, bus.L_S}, 32'd0);
    check("lux0.rdy", {31'd0, bus.lu_ready}, 32'd1);

    // Set vs clear: reissue r9 while its FIFO write is on the port
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h01;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd9; bus.lu_data = 32'h0000_0099;
    tick();
    idle_inputs();
    tick();
    expect_write("svc.r9", 5'd9, 32'h0000_0099);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    check("svc.busy9", bus.busy, 32'h0000_0200);
    tick();
    check("svc.busy9_stays", bus.busy, 32'h0000_0200);

    // Latency from acceptance with an idle pipeline and empty FIFO
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd20;
    tick();
    bus.iss_valid = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd20; bus.lu_data = 32'hCAFE_0020;
    tick();
    bus.lu_valid = 1'b0;
`ifdef WB_WRITER_BYPASS_EN
    expect_write("lat.n1", 5'd20, 32'hCAFE_0020);
    tick();
    check("lat.n2_L_S", {31'd0, bus.L_S}, 32'd0);
    check("lat.n2_busy", bus.busy, 32'h0000_0200);
`else
    check("lat.n1_L_S", {31'd0, bus.L_S}, 32'd0);
    tick();
    expect_write("lat.n2", 5'd20, 32'hCAFE_0020);
    check("lat.n2_busy", bus.busy, 32'h0010_0200);
`endif
    tick();
    check("lat.n3_busy", bus.busy, 32'h0000_0200);

    // Reset mid-operation discards buffered results
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h66;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd13; bus.lu_data = 32'h1313_1313;
    tick();
    bus.lu_addr = 5'd14; bus.lu_data = 32'h1414_1414;
    tick();
    check("mid.full", {31'd0, bus.lu_ready}, 32'd0);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.busy", bus.busy, 32'd0);
    check("mid.rdy", {31'd0, bus.lu_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mid.no_write", {31'd0, bus.L_S}, 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
